// File: rtl/wasm_pkg.sv
// Purpose: shared op/fault encodings and default sizes for the wasm control stack.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package wasm_pkg;

    localparam int CTRL_STACK_DEPTH = 64;
    localparam int CALL_FRAME_DEPTH = 16;

    typedef enum logic [2:0] {
        OP_NOP     = 3'd0,
        OP_PUSH    = 3'd1,
        OP_POP     = 3'd2,
        OP_REPLACE = 3'd3,
        OP_BRANCH  = 3'd4,
        OP_CALL    = 3'd5,
        OP_RETURN  = 3'd6,
        OP_RSVD    = 3'd7
    } ctrl_op_e;

    typedef enum logic [2:0] {
        ERR_NONE     = 3'd0,
        ERR_LBL_OVF  = 3'd1,
        ERR_LBL_UNF  = 3'd2,
        ERR_BR_RANGE = 3'd3,
        ERR_FRM_OVF  = 3'd4,
        ERR_FRM_UNF  = 3'd5,
        ERR_ILLEGAL  = 3'd6
    } ctrl_err_e;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/wasm_ctrl_frame_stack_if.sv
// Purpose: op request / stack status bundle between control FSM (master) and stack (slave).
// Latency: wires only; status is combinational from stack state.
// Backpressure: op_ready low while a sticky fault is pending. WASM_CSTK_HWM_EN adds hwm/hwm_clr.
interface wasm_ctrl_frame_stack_if #(
    parameter int DEPTH       = 64,
    parameter int ENTRY_W     = 64,
    parameter int FRAME_DEPTH = 16,
    parameter int SP_W        = $clog2(DEPTH + 1),
    parameter int FP_W        = $clog2(FRAME_DEPTH + 1)
);
    logic               op_valid;
    logic               op_ready;
    logic [2:0]         op_code;
    logic [ENTRY_W-1:0] op_data;
    logic [7:0]         op_depth;
    logic               err_clr;
    logic [ENTRY_W-1:0] top_data;
    logic [ENTRY_W-1:0] branch_target;
    logic               branch_ok;
    logic [SP_W-1:0]    sp;
    logic [SP_W-1:0]    frame_base;
    logic [FP_W-1:0]    fp;
    logic               empty;
    logic               full;
    logic               err;
    logic [2:0]         err_code;
`ifdef WASM_CSTK_HWM_EN
    logic [SP_W-1:0]    hwm;
    logic               hwm_clr;

    modport master (
        output op_valid, op_code, op_data, op_depth, err_clr, hwm_clr,
        input  op_ready, top_data, branch_target, branch_ok, sp, frame_base, fp,
               empty, full, err, err_code, hwm
    );
    modport slave (
        input  op_valid, op_code, op_data, op_depth, err_clr, hwm_clr,
        output op_ready, top_data, branch_target, branch_ok, sp, frame_base, fp,
               empty, full, err, err_code, hwm
    );
`else
    modport master (
        output op_valid, op_code, op_data, op_depth, err_clr,
        input  op_ready, top_data, branch_target, branch_ok, sp, frame_base, fp,
               empty, full, err, err_code
    );
    modport slave (
        input  op_valid, op_code, op_data, op_depth, err_clr,
        output op_ready, top_data, branch_target, branch_ok, sp, frame_base, fp,
               empty, full, err, err_code
    );
`endif
endinterface

// File: rtl/wasm_ctrl_frame_ptr_stack.sv
// Purpose: LIFO of saved frame-base pointers, one entry per active call.
// Latency: push/pop visible next cycle; top_base is combinational.
// Backpressure: none; caller must not push when full or pop when empty.
module wasm_ctrl_frame_ptr_stack #(
    parameter int FRAME_DEPTH = 16,
    parameter int SP_W        = 7,
    parameter int FP_W        = $clog2(FRAME_DEPTH + 1)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            push,
    input  logic            pop,
    input  logic [SP_W-1:0] push_base,
    output logic [SP_W-1:0] top_base,
    output logic [FP_W-1:0] fp,
    output logic            full,
    output logic            empty
);
    localparam int FAW = (FRAME_DEPTH > 1) ? $clog2(FRAME_DEPTH) : 1;

    logic [SP_W-1:0] fstack [FRAME_DEPTH];
    logic [FP_W-1:0] fp_m1;
    logic            unused_bits;

    assign full        = (fp == FP_W'(FRAME_DEPTH));
    assign empty       = (fp == '0);
    assign fp_m1       = fp - FP_W'(1);
    assign top_base    = empty ? '0 : fstack[fp_m1[FAW-1:0]];
    assign unused_bits = ^fp_m1;

    // Frame pointer moves one slot per accepted call/return.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fp <= '0;
        end else if (push) begin
            fp <= fp + FP_W'(1);
        end else if (pop) begin
            fp <= fp_m1;
        end
    end

    // Saved bases are never reset; fp gates every read.
    always_ff @(posedge clk) begin
        if (push) begin
            fstack[fp[FAW-1:0]] <= push_base;
        end
    end

endmodule

// File: rtl/wasm_ctrl_frame_stack.sv
// Purpose: wasm label stack with frame-relative branches and hardware call/return frames.
// Latency: accepted op updates state on the next edge; read outputs are combinational.
// Backpressure: op_ready = !err; a faulting op stalls until err_clr. Option: WASM_CSTK_HWM_EN.
module wasm_ctrl_frame_stack
    import wasm_pkg::*;
#(
    parameter int DEPTH       = CTRL_STACK_DEPTH,
    parameter int ENTRY_W     = 64,
    parameter int FRAME_DEPTH = CALL_FRAME_DEPTH
) (
    input logic                   clk,
    input logic                   rst_n,
    wasm_ctrl_frame_stack_if.slave bus
);
    localparam int SP_W = $clog2(DEPTH + 1);
    localparam int FP_W = $clog2(FRAME_DEPTH + 1);
    localparam int AW   = $clog2(DEPTH);
    // Wide enough for sp+1 and for an unclipped 8-bit op_depth.
    localparam int CW   = max_int(SP_W + 1, 9);

    logic [ENTRY_W-1:0] mem [DEPTH];
    logic [SP_W-1:0]    sp, sp_nxt;
    logic [SP_W-1:0]    frame_base, fb_nxt;
    logic               err;
    ctrl_err_e          err_code, fault_code;
    logic [CW-1:0]      sp_x, fb_x, depth_x, count_x, top_idx, br_idx;
    logic               empty, full, branch_ok, accept;
    logic               mem_we;
    logic [AW-1:0]      mem_waddr;
    logic               f_push, f_pop, f_full, f_empty;
    logic [SP_W-1:0]    f_top;
    logic [FP_W-1:0]    fp;
    logic               unused_bits;

    wasm_ctrl_frame_ptr_stack #(
        .FRAME_DEPTH (FRAME_DEPTH),
        .SP_W        (SP_W),
        .FP_W        (FP_W)
    ) u_frames (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (f_push),
        .pop       (f_pop),
        .push_base (frame_base),
        .top_base  (f_top),
        .fp        (fp),
        .full      (f_full),
        .empty     (f_empty)
    );

    assign sp_x        = CW'(sp);
    assign fb_x        = CW'(frame_base);
    assign depth_x     = CW'(bus.op_depth);
    assign count_x     = sp_x - fb_x;
    assign top_idx     = sp_x - CW'(1);
    assign br_idx      = sp_x - depth_x - CW'(1);
    assign empty       = (sp == frame_base);
    assign full        = (sp == SP_W'(DEPTH));
    assign branch_ok   = (depth_x < count_x);
    assign accept      = bus.op_valid && !err;
    assign unused_bits = ^{top_idx[CW-1:AW], br_idx[CW-1:AW]};

    assign bus.op_ready      = !err;
    assign bus.top_data      = empty ? '0 : mem[top_idx[AW-1:0]];
    assign bus.branch_target = branch_ok ? mem[br_idx[AW-1:0]] : '0;
    assign bus.branch_ok     = branch_ok;
    assign bus.sp            = sp;
    assign bus.frame_base    = frame_base;
    assign bus.fp            = fp;
    assign bus.empty         = empty;
    assign bus.full          = full;
    assign bus.err           = err;
    assign bus.err_code      = err_code;

    // Decode the accepted op into next-state and a fault; a fault suppresses every update.
    always_comb begin
        sp_nxt     = sp;
        fb_nxt     = frame_base;
        mem_we     = 1'b0;
        mem_waddr  = sp_x[AW-1:0];
        f_push     = 1'b0;
        f_pop      = 1'b0;
        fault_code = ERR_NONE;
        if (accept) begin
            case (ctrl_op_e'(bus.op_code))
                OP_PUSH: begin
                    if (full) fault_code = ERR_LBL_OVF;
                    else begin
                        mem_we = 1'b1;
                        sp_nxt = sp + SP_W'(1);
                    end
                end
                OP_POP: begin
                    if (empty) fault_code = ERR_LBL_UNF;
                    else sp_nxt = sp - SP_W'(1);
                end
                OP_REPLACE: begin
                    if (empty) fault_code = ERR_LBL_UNF;
                    else begin
                        mem_we    = 1'b1;
                        mem_waddr = top_idx[AW-1:0];
                    end
                end
                OP_BRANCH: begin
                    if (!branch_ok) fault_code = ERR_BR_RANGE;
                    else sp_nxt = br_idx[SP_W-1:0];
                end
                OP_CALL: begin
                    if (f_full) fault_code = ERR_FRM_OVF;
                    else begin
                        f_push = 1'b1;
                        fb_nxt = sp;
                    end
                end
                OP_RETURN: begin
                    if (f_empty) fault_code = ERR_FRM_UNF;
                    else begin
                        f_pop  = 1'b1;
                        sp_nxt = frame_base;
                        fb_nxt = f_top;
                    end
                end
                OP_RSVD: fault_code = ERR_ILLEGAL;
                default: ;
            endcase
        end
    end

    // Pointer state and sticky fault; a fresh fault outranks a coincident clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sp         <= '0;
            frame_base <= '0;
            err        <= 1'b0;
            err_code   <= ERR_NONE;
        end else begin
            sp         <= sp_nxt;
            frame_base <= fb_nxt;
            if (fault_code != ERR_NONE) begin
                err      <= 1'b1;
                err_code <= fault_code;
            end else if (bus.err_clr) begin
                err      <= 1'b0;
                err_code <= ERR_NONE;
            end
        end
    end

    // Label entries are not reset; empty/branch_ok gate every read.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[mem_waddr] <= bus.op_data;
        end
    end

`ifdef WASM_CSTK_HWM_EN
    logic [SP_W-1:0] hwm;

    // Track the deepest sp seen; clear re-seeds from the live sp.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hwm <= '0;
        end else if (bus.hwm_clr) begin
            hwm <= sp;
        end else if (sp > hwm) begin
            hwm <= sp;
        end
    end

    assign bus.hwm = hwm;
`endif

endmodule

// File: tb/tb_wasm_ctrl_frame_stack.sv
// Purpose: directed table plus hand sequences for the wasm control/frame stack.
// Latency: checks sample #1 after the active edge, or mid-low-phase for combinational reads.
// Backpressure: exercises op_ready drop on fault and recovery through err_clr.
module tb_wasm_ctrl_frame_stack;
    import wasm_pkg::*;

    localparam int DEPTH = 8;
    localparam int EW    = 16;
    localparam int FD    = 4;

    logic clk;
    logic rst_n;
    int   checks;
    int   errors;

    wasm_ctrl_frame_stack_if #(.DEPTH(DEPTH), .ENTRY_W(EW), .FRAME_DEPTH(FD)) bus ();

    wasm_ctrl_frame_stack #(.DEPTH(DEPTH), .ENTRY_W(EW), .FRAME_DEPTH(FD)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]  code;
        logic [15:0] data;
        logic [7:0]  depth;
        logic        clr;
        int          sp;
        int          fb;
        int          fp;
        logic [15:0] top;
        logic        err;
        logic [2:0]  ecode;
    } vec_t;

    vec_t vt [22];

    function automatic vec_t mk(input logic [2:0] code, input logic [15:0] data,
                                input logic [7:0] depth, input logic clr,
                                input int sp, input int fb, input int fp,
                                input logic [15:0] top, input logic err, input logic [2:0] ecode);
        vec_t v;
        v.code = code; v.data = data; v.depth = depth; v.clr = clr;
        v.sp = sp; v.fb = fb; v.fp = fp; v.top = top; v.err = err; v.ecode = ecode;
        return v;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic check_state(input string tag, input int sp, input int fb, input int fp,
                               input logic [15:0] top, input logic err, input logic [2:0] ecode);
        chk({tag, "_sp"},       64'(bus.sp),         64'(sp));
        chk({tag, "_fb"},       64'(bus.frame_base), 64'(fb));
        chk({tag, "_fp"},       64'(bus.fp),         64'(fp));
        chk({tag, "_top"},      64'(bus.top_data),   64'(top));
        chk({tag, "_err"},      64'(bus.err),        64'(err));
        chk({tag, "_code"},     64'(bus.err_code),   64'(ecode));
        chk({tag, "_ready"},    64'(bus.op_ready),   64'(!err));
        chk({tag, "_empty"},    64'(bus.empty),      64'(sp == fb));
        chk({tag, "_full"},     64'(bus.full),       64'(sp == DEPTH));
    endtask

    // Drive one op in the low phase, let it take the rising edge, then release.
    task automatic step(input logic [2:0] code, input logic [15:0] data,
                        input logic [7:0] depth, input logic clr);
        @(negedge clk);
        bus.op_valid = 1'b1;
        bus.op_code  = code;
        bus.op_data  = data;
        bus.op_depth = depth;
        bus.err_clr  = clr;
        @(posedge clk);
        #1;
        bus.op_valid = 1'b0;
        bus.err_clr  = 1'b0;
        bus.op_depth = 8'd0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        bus.op_valid = 1'b0;
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        checks = 0;
        errors = 0;
        clk = 1'b0;
        rst_n = 1'b0;
        bus.op_valid = 1'b0;
        bus.op_code  = 3'd0;
        bus.op_data  = '0;
        bus.op_depth = 8'd0;
        bus.err_clr  = 1'b0;
`ifdef WASM_CSTK_HWM_EN
        bus.hwm_clr  = 1'b0;
`endif
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Reset state.
        check_state("reset", 0, 0, 0, 16'h0, 1'b0, 3'd0);
        chk("reset_brok", 64'(bus.branch_ok), 64'd0);
        chk("reset_brtgt", 64'(bus.branch_target), 64'd0);

        // Branch target is readable combinationally before the edge.
        step(OP_PUSH, 16'h00A1, 8'd0, 1'b0);
        step(OP_PUSH, 16'h00B2, 8'd0, 1'b0);
        step(OP_PUSH, 16'h00C3, 8'd0, 1'b0);
        @(negedge clk);
        bus.op_code  = OP_BRANCH;
        bus.op_depth = 8'd2;
        #1;
        chk("br_d2_tgt", 64'(bus.branch_target), 64'h00A1);
        bus.op_depth = 8'd3;
        #1;
        chk("br_d3_ok", 64'(bus.branch_ok), 64'd0);
        chk("br_d3_tgt", 64'(bus.branch_target), 64'd0);
        bus.op_depth = 8'd200;
        #1;
        chk("br_d200_ok", 64'(bus.branch_ok), 64'd0);
        bus.op_depth = 8'd1;
        bus.op_valid = 1'b1;
        #1;
        chk("br_d1_ok", 64'(bus.branch_ok), 64'd1);
        chk("br_d1_tgt", 64'(bus.branch_target), 64'h00B2);
        @(posedge clk);
        #1;
        bus.op_valid = 1'b0;
        check_state("br_after", 1, 0, 0, 16'h00A1, 1'b0, 3'd0);

        // Table-driven sequence from a clean reset.
        vt[0]  = mk(OP_PUSH,    16'h00A1, 8'd0, 1'b0, 1, 0, 0, 16'h00A1, 1'b0, 3'd0);
        vt[1]  = mk(OP_PUSH,    16'h00B2, 8'd0, 1'b0, 2, 0, 0, 16'h00B2, 1'b0, 3'd0);
        vt[2]  = mk(OP_PUSH,    16'h00C3, 8'd0, 1'b0, 3, 0, 0, 16'h00C3, 1'b0, 3'd0);
        vt[3]  = mk(OP_BRANCH,  16'h0000, 8'd1, 1'b0, 1, 0, 0, 16'h00A1, 1'b0, 3'd0);
        vt[4]  = mk(OP_REPLACE, 16'h0D0D, 8'd0, 1'b0, 1, 0, 0, 16'h0D0D, 1'b0, 3'd0);
        vt[5]  = mk(OP_POP,     16'h0000, 8'd0, 1'b0, 0, 0, 0, 16'h0000, 1'b0, 3'd0);
        vt[6]  = mk(OP_POP,     16'h0000, 8'd0, 1'b0, 0, 0, 0, 16'h0000, 1'b1, 3'd2);
        vt[7]  = mk(OP_PUSH,    16'h1111, 8'd0, 1'b0, 0, 0, 0, 16'h0000, 1'b1, 3'd2);
        vt[8]  = mk(OP_NOP,     16'h0000, 8'd0, 1'b1, 0, 0, 0, 16'h0000, 1'b0, 3'd0);
        vt[9]  = mk(OP_PUSH,    16'h1111, 8'd0, 1'b0, 1, 0, 0, 16'h1111, 1'b0, 3'd0);
        vt[10] = mk(OP_CALL,    16'h0000, 8'd0, 1'b0, 1, 1, 1, 16'h0000, 1'b0, 3'd0);
        vt[11] = mk(OP_PUSH,    16'h2222, 8'd0, 1'b0, 2, 1, 1, 16'h2222, 1'b0, 3'd0);
        vt[12] = mk(OP_BRANCH,  16'h0000, 8'd1, 1'b0, 2, 1, 1, 16'h2222, 1'b1, 3'd3);
        vt[13] = mk(OP_RETURN,  16'h0000, 8'd0, 1'b1, 2, 1, 1, 16'h2222, 1'b0, 3'd0);
        vt[14] = mk(OP_RETURN,  16'h0000, 8'd0, 1'b0, 1, 0, 0, 16'h1111, 1'b0, 3'd0);
        vt[15] = mk(OP_RETURN,  16'h0000, 8'd0, 1'b0, 1, 0, 0, 16'h1111, 1'b1, 3'd5);
        vt[16] = mk(OP_NOP,     16'h0000, 8'd0, 1'b1, 1, 0, 0, 16'h1111, 1'b0, 3'd0);
        vt[17] = mk(OP_RSVD,    16'h0000, 8'd0, 1'b0, 1, 0, 0, 16'h1111, 1'b1, 3'd6);
        vt[18] = mk(OP_NOP,     16'h0000, 8'd0, 1'b1, 1, 0, 0, 16'h1111, 1'b0, 3'd0);
        vt[19] = mk(OP_BRANCH,  16'h0000, 8'd0, 1'b0, 0, 0, 0, 16'h0000, 1'b0, 3'd0);
        vt[20] = mk(OP_POP,     16'h0000, 8'd0, 1'b1, 0, 0, 0, 16'h0000, 1'b1, 3'd2);
        vt[21] = mk(OP_NOP,     16'h0000, 8'd0, 1'b1, 0, 0, 0, 16'h0000, 1'b0, 3'd0);

        do_reset();
        for (int i = 0; i < 22; i++) begin
            step(vt[i].code, vt[i].data, vt[i].depth, vt[i].clr);
            check_state($sformatf("row%0d", i), vt[i].sp, vt[i].fb, vt[i].fp,
                        vt[i].top, vt[i].err, vt[i].ecode);
        end

        // Label overflow at DEPTH, then recovery through err_clr.
        do_reset();
        for (int i = 0; i < DEPTH; i++) begin
            step(OP_PUSH, 16'(i + 1), 8'd0, 1'b0);
        end
        check_state("fill", DEPTH, 0, 0, 16'(DEPTH), 1'b0, 3'd0);
        step(OP_PUSH, 16'h0099, 8'd0, 1'b0);
        check_state("ovf", DEPTH, 0, 0, 16'(DEPTH), 1'b1, 3'd1);
        step(OP_NOP, 16'h0000, 8'd0, 1'b1);
        check_state("ovf_clr", DEPTH, 0, 0, 16'(DEPTH), 1'b0, 3'd0);
        step(OP_POP, 16'h0000, 8'd0, 1'b0);
        check_state("ovf_pop", DEPTH - 1, 0, 0, 16'(DEPTH - 1), 1'b0, 3'd0);

        // Frame overflow at FRAME_DEPTH, then unwind to frame underflow.
        do_reset();
        for (int i = 0; i < FD; i++) begin
            step(OP_CALL, 16'h0000, 8'd0, 1'b0);
        end
        check_state("calls", 0, 0, FD, 16'h0, 1'b0, 3'd0);
        step(OP_CALL, 16'h0000, 8'd0, 1'b0);
        check_state("fovf", 0, 0, FD, 16'h0, 1'b1, 3'd4);
        step(OP_NOP, 16'h0000, 8'd0, 1'b1);
        for (int i = 0; i < FD; i++) begin
            step(OP_RETURN, 16'h0000, 8'd0, 1'b0);
        end
        check_state("unwound", 0, 0, 0, 16'h0, 1'b0, 3'd0);
        step(OP_RETURN, 16'h0000, 8'd0, 1'b0);
        check_state("funf", 0, 0, 0, 16'h0, 1'b1, 3'd5);

        // Asynchronous reset mid-sequence clears everything at once.
        do_reset();
        step(OP_PUSH, 16'h0011, 8'd0, 1'b0);
        step(OP_PUSH, 16'h0022, 8'd0, 1'b0);
        step(OP_PUSH, 16'h0033, 8'd0, 1'b0);
        step(OP_CALL, 16'h0000, 8'd0, 1'b0);
        check_state("pre_rst", 3, 3, 1, 16'h0, 1'b0, 3'd0);
`ifdef WASM_CSTK_HWM_EN
        chk("hwm_pre", 64'(bus.hwm), 64'd3);
`endif
        step(OP_RSVD, 16'h0000, 8'd0, 1'b0);
        chk("pre_rst_err", 64'(bus.err), 64'd1);
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check_state("mid_rst", 0, 0, 0, 16'h0, 1'b0, 3'd0);
`ifdef WASM_CSTK_HWM_EN
        chk("hwm_rst", 64'(bus.hwm), 64'd0);
`endif
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check_state("post_rst", 0, 0, 0, 16'h0, 1'b0, 3'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
